// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds two WIDTH-bit operands one nibble per clock, LSB
// first, using an external combinational 4-bit adder. The carry-out of each
// nibble feeds the carry-in of the next.
// Optional feature macro: NIBBLE_SUB_EN adds an in_sub port. When in_sub is high,
// the block computes A-B as A + ~B + 1.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef NIBBLE_SUB_EN
  input  logic             in_sub,
`endif
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_c,
  input  logic [3:0]       add_sum,
  input  logic             add_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned NIB      = WIDTH / 4;
  localparam int unsigned IDXW     = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  // Operands shift right one nibble per RUN step, so the adder always sees bit 0..3.
  // Zeros shift in, so both registers are empty again once the operation completes.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  // Collects the low NIB-1 sum nibbles; the final nibble comes straight from the adder.
  logic [WIDTH-5:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic             sub_c;
  logic [WIDTH-1:0] res_cat_c;

`ifdef NIBBLE_SUB_EN
  assign sub_c = in_sub;
`else
  assign sub_c = 1'b0;
`endif

  assign res_cat_c = {add_sum, res_q};

  // Next-state and next-output logic for the sequencer
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    res_d       = res_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = in_a;
          b_d        = sub_c ? ~in_b : in_b;
          carry_d    = sub_c ? 1'b1 : in_cin;
          idx_d      = '0;
          state_d    = S_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        res_d   = res_cat_c[WIDTH-1:4];
        carry_d = add_carry;
        if (idx_q == LAST_IDX) begin
          state_d     = S_DONE;
          idx_d       = '0;
          carry_d     = 1'b0;
          sum_d       = res_cat_c;
          cout_d      = add_carry;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      res_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign add_a     = a_q[3:0];
  assign add_b     = b_q[3:0];
  assign add_c     = carry_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl (WIDTH=16).
// Uses a combinational 4-bit adder model, a fixed vector table, hand-written
// corner sequences, and random operations checked against plain arithmetic.
module tb_nibble_serial_add_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
`ifdef NIBBLE_SUB_EN
  logic             in_sub;
`endif
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_c;
  logic [3:0]       add_sum;
  logic             add_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Shared external adder: purely combinational
  assign {add_carry, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_c);

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef NIBBLE_SUB_EN
    .in_sub    (in_sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .add_sum   (add_sum),
    .add_carry (add_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] es;
    logic        ec;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Present operands and wait (bounded) for the accept edge; returns at the
  // falling edge of the first RUN cycle.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int g;
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("accept_timeout", 32'(g >= 100), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // One full operation with per-nibble adder checks, latency, optional stall, handshake
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [15:0] es, input logic ec,
                        input int stall);
    logic [15:0] bb;
    logic        c0;
    int unsigned mask;
    int unsigned cin_k;
    bb = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
`ifdef NIBBLE_SUB_EN
    in_sub = sub;
`endif
    start_op(a, b, cin);
    for (int k = 0; k < int'(NIB); k++) begin
      mask  = (32'd1 << (4 * k)) - 32'd1;
      cin_k = ((32'(a) & mask) + (32'(bb) & mask) + 32'(c0)) >> (4 * k);
      check("add_a", 32'(add_a), (32'(a) >> (4 * k)) & 32'hF);
      check("add_b", 32'(add_b), (32'(bb) >> (4 * k)) & 32'hF);
      check("add_c", 32'(add_c), cin_k);
      check("run_out_valid", 32'(out_valid), 32'd0);
      check("run_in_ready", 32'(in_ready), 32'd0);
      check("run_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("out_sum", 32'(out_sum), 32'(es));
    check("out_cout", 32'(out_cout), 32'(ec));
    for (int s = 0; s < stall; s++) begin
      in_valid  = 1'b1;
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_cin    = 1'($urandom);
      out_ready = 1'b0;
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_sum", 32'(out_sum), 32'(es));
      check("stall_out_cout", 32'(out_cout), 32'(ec));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_add_a", 32'(add_a), 32'd0);
    end
    out_ready = 1'b1;
    check("hs_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    check("idle_hold_sum", 32'(out_sum), 32'(es));
    check("idle_hold_cout", 32'(out_cout), 32'(ec));
    check("idle_add_abc", {23'd0, add_a, add_b, add_c}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb, rbb;
    logic        rcin, rsub;
    logic [16:0] r;

    tbl[0] = '{a: 16'h1234, b: 16'h0FCD, cin: 1'b0, sub: 1'b0, es: 16'h2201, ec: 1'b0};
    tbl[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, es: 16'h0000, ec: 1'b1};
    tbl[2] = '{a: 16'h0007, b: 16'h0009, cin: 1'b1, sub: 1'b0, es: 16'h0011, ec: 1'b0};
    tbl[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sub: 1'b0, es: 16'h0000, ec: 1'b1};
    tbl[4] = '{a: 16'hABCD, b: 16'h1111, cin: 1'b1, sub: 1'b0, es: 16'hBCDF, ec: 1'b0};
    tbl[5] = '{a: 16'h0000, b: 16'h0000, cin: 1'b1, sub: 1'b0, es: 16'h0001, ec: 1'b0};
    tbl[6] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sub: 1'b0, es: 16'hFFFF, ec: 1'b1};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
`ifdef NIBBLE_SUB_EN
    in_sub    = 1'b0;
`endif
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_add_abc", {23'd0, add_a, add_b, add_c}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed vectors
    for (int i = 0; i < 7; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].es, tbl[i].ec, 0);

    // Stall in DONE for 5 cycles with new operands offered, then a clean op
    run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 5);
    run_op(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 0);

    // Reset after two RUN cycles aborts the operation
`ifdef NIBBLE_SUB_EN
    in_sub = 1'b0;
`endif
    start_op(16'hF234, 16'h0FCD, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_sum", 32'(out_sum), 32'd0);
    check("abort_out_cout", 32'(out_cout), 32'd0);
    check("abort_add_abc", {23'd0, add_a, add_b, add_c}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 0);

`ifdef NIBBLE_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0);
    run_op(16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0006, 1'b1, 0);
`endif

    // Random operations against plain arithmetic
    for (int i = 0; i < 30; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rcin = 1'($urandom);
`ifdef NIBBLE_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      if (rsub) begin
        rbb = ~rb;
        r   = 17'(ra) + 17'(rbb) + 17'd1;
      end else begin
        r   = 17'(ra) + 17'(rb) + 17'(rcin);
      end
      run_op(ra, rb, rcin, rsub, r[15:0], r[16], int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
